// File: rtl/sdrc_wb_arbiter.sv
// rtl/sdrc_wb_arbiter.sv - round-robin Wishbone arbiter sharing the SDRAM controller slave port
// Ownership spans a whole wb_cyc; a per-transfer ack watchdog errors the owner out if the controller stalls.
module sdrc_wb_arbiter #(
    parameter int NUM_MST = 2,
    parameter int APP_AW  = 26,
    parameter int DW      = 32,
    parameter int BW      = 4,
    parameter int TMO_W   = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_MST-1:0]      m_cyc_i,
    input  logic [NUM_MST-1:0]      m_stb_i,
    input  logic [NUM_MST-1:0]      m_we_i,
    input  logic [NUM_MST*APP_AW-1:0] m_addr_i,
    input  logic [NUM_MST*DW-1:0]   m_dat_i,
    input  logic [NUM_MST*BW-1:0]   m_sel_i,
    input  logic [NUM_MST*3-1:0]    m_cti_i,
    output logic [NUM_MST-1:0]      m_ack_o,
    output logic [NUM_MST-1:0]      m_err_o,
    output logic [DW-1:0]           m_dat_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [APP_AW-1:0]       s_addr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [BW-1:0]           s_sel_o,
    output logic [2:0]              s_cti_o,
    input  logic                    s_ack_i,
    input  logic [DW-1:0]           s_dat_i,
    output logic [NUM_MST-1:0]      gnt_o
);
    localparam int LW = (NUM_MST > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ERR = 2'd2} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_MST-1:0] r_gnt;
    logic [LW-1:0]      r_gidx;
    logic [LW-1:0]      r_last;
    logic [LW-1:0]      w_pick;
    logic [TMO_W-1:0]   r_wdog;
    logic [NUM_MST-1:0] w_req;
    logic               w_any;
    logic               w_cyc_g;
    logic               w_stb_g;
    logic               w_tmo;
    logic               w_load;
    logic               w_release;

    assign w_req   = m_cyc_i & m_stb_i;
    assign w_cyc_g = m_cyc_i[r_gidx];
    assign w_stb_g = w_cyc_g & m_stb_i[r_gidx];
    // An ack in the final watchdog cycle still completes the transfer normally.
    assign w_tmo   = (r_state == GRANT) && w_stb_g && !s_ack_i && (r_wdog == {TMO_W{1'b1}});
    assign gnt_o   = r_gnt;
    assign m_dat_o = s_dat_i;

    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = r_last;
        for (int k = 1; k <= NUM_MST; k++) begin
            idx = (int'(r_last) + k) % NUM_MST;
            if (!w_any && w_req[idx]) begin
                w_any  = 1'b1;
                w_pick = LW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_load      = 1'b1;
                end
            end
            GRANT: begin
                if (w_tmo) begin
                    w_state_nxt = ERR;
                end else if (!w_cyc_g) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end
            end
            ERR: begin
                if (!w_cyc_g) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= LW'(NUM_MST - 1);
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gnt  <= {{(NUM_MST-1){1'b0}}, 1'b1} << w_pick;
                r_gidx <= w_pick;
            end
            if (w_release) begin
                r_gnt  <= '0;
                r_last <= r_gidx;
            end
            if (r_state != GRANT || s_ack_i || w_tmo) begin
                r_wdog <= '0;
            end else if (w_stb_g) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    // Outside GRANT the controller sees an idle bus and late acks are swallowed.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        m_ack_o  = '0;
        m_err_o  = '0;
        if (r_state == GRANT) begin
            s_cyc_o  = w_cyc_g & ~w_tmo;
            s_stb_o  = w_stb_g & ~w_tmo;
            s_we_o   = m_we_i[r_gidx];
            s_addr_o = m_addr_i[int'(r_gidx)*APP_AW +: APP_AW];
            s_dat_o  = m_dat_i[int'(r_gidx)*DW +: DW];
            s_sel_o  = m_sel_i[int'(r_gidx)*BW +: BW];
            s_cti_o  = m_cti_i[int'(r_gidx)*3 +: 3];
            m_ack_o[r_gidx] = s_ack_i;
            m_err_o[r_gidx] = w_tmo;
        end
    end
endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// tb/tb_sdrc_wb_arbiter.sv - scoreboard bench for sdrc_wb_arbiter with a registered-ack slave model
module tb_sdrc_wb_arbiter;
    localparam int NM = 2;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b1;
    logic [NM-1:0]     m_cyc_i = '0;
    logic [NM-1:0]     m_stb_i = '0;
    logic [NM-1:0]     m_we_i = '0;
    logic [NM*AW-1:0]  m_addr_i = '0;
    logic [NM*DW-1:0]  m_dat_i = '0;
    logic [NM*BW-1:0]  m_sel_i = '0;
    logic [NM*3-1:0]   m_cti_i = '0;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [DW-1:0]     m_dat_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_dat_o;
    logic [BW-1:0]     s_sel_o;
    logic [2:0]        s_cti_o;
    logic              s_ack_i;
    logic [DW-1:0]     s_dat_i;
    logic [NM-1:0]     gnt_o;

    sdrc_wb_arbiter #(.NUM_MST(NM), .APP_AW(AW), .DW(DW), .BW(BW), .TMO_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave: one wait state, ack for a single cycle, gated by slv_en to model a stall.
    logic [31:0] smem [0:1023];
    logic        slv_en = 1'b1;
    logic        r_sack;
    logic [31:0] r_sdat;
    assign s_ack_i = r_sack;
    assign s_dat_i = r_sdat;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sack <= 1'b0;
        end else if (s_cyc_o && s_stb_o && !r_sack && slv_en) begin
            r_sack <= 1'b1;
            if (s_we_o) smem[s_addr_o[9:0]] <= s_dat_o;
            r_sdat <= smem[s_addr_o[9:0]];
        end else begin
            r_sack <= 1'b0;
        end
    end

    logic [NM-1:0] gnt_q [$];
    logic [31:0]   rd_q [$];
    logic [31:0]   gold [int];
    int            err_cnt = 0;
    int            stb_cnt = 0;
    bit            contend = 0;

    initial begin
        logic          pc;
        logic [NM-1:0] pg;
        int            gap;
        bit            fell;
        logic [NM-1:0] eg;
        logic [31:0]   ed;
        pc = 1'b0; pg = '0; gap = 0; fell = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                pc = 1'b0; pg = '0; gap = 0; fell = 0;
            end else begin
                if (s_cyc_o && !pc) begin
                    if (gnt_q.size() == 0) chk("gnt_unexpected", gnt_q.size(), 1);
                    else begin
                        eg = gnt_q.pop_front();
                        chk("gnt_order", gnt_o, eg);
                    end
                end
                if (gnt_o == 0) begin
                    if (pg != 0) begin fell = 1; gap = 0; end
                    gap++;
                end else if (pg == 0) begin
                    if (contend && fell) chk("idle_gap", gap, 1);
                    fell = 0;
                end
                if (s_ack_i || m_ack_o != 0) begin
                    chk("ack_fwd", m_ack_o, gnt_o & {NM{s_ack_i}});
                    if (!s_we_o) begin
                        if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
                        else begin
                            ed = rd_q.pop_front();
                            chk("rd_data", m_dat_o, ed);
                        end
                    end
                end
                if (m_err_o != 0) begin
                    err_cnt++;
                    chk("err_owner", m_err_o & ~gnt_o, 0);
                end
                if (s_stb_o && !s_ack_i) stb_cnt++;
                pc = s_cyc_o;
                pg = gnt_o;
            end
        end
    end

    task automatic beat(input int m, input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [2:0] cti, input bit drop, output bit ok);
        bit err_seen;
        bit rst_seen;
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
        m_we_i[m]  = we;
        m_addr_i[m*AW +: AW] = a;
        m_dat_i[m*DW +: DW]  = d;
        m_sel_i[m*BW +: BW]  = 4'hF;
        m_cti_i[m*3 +: 3]    = cti;
        if (!we) rd_q.push_back(gold[int'(a)]);
        ok = 0; err_seen = 0; rst_seen = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin rst_seen = 1; break; end
            if (m_err_o[m]) begin err_seen = 1; break; end
            if (m_ack_o[m]) begin ok = 1; break; end
        end
        if (ok) begin
            chk("ack_cti", s_cti_o, cti);
            chk("ack_addr", s_addr_o, a);
            if (we) gold[int'(a)] = d;
        end else if (!err_seen && !rst_seen) begin
            chk("beat_timeout", ok, 1);
        end
        @(posedge wb_clk_i); #1;
        m_stb_i[m] = 1'b0;
        if (drop || !ok) begin
            m_cyc_i[m] = 1'b0;
            @(posedge wb_clk_i); #1;
        end
    endtask

    task automatic burst(input int m, input logic [AW-1:0] a, input logic [31:0] d, output bit ok);
        for (int k = 0; k < 4; k++) begin
            beat(m, 1'b1, a + AW'(k), d + k, (k == 3) ? 3'b111 : 3'b010, k == 3, ok);
            if (!ok) break;
        end
    endtask

    task automatic do_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
    endtask

    bit ok0, ok1, seen;

    initial begin
        @(negedge wb_clk_i);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // single master write with latency check, then read back
        gnt_q.push_back(2'b01);
        fork
            beat(0, 1'b1, 26'h0000100, 32'hDEADBEEF, 3'b000, 1'b1, ok0);
            begin
                @(negedge wb_clk_i);
                chk("lat_idle", s_stb_o, 0);
                @(negedge wb_clk_i);
                chk("lat_stb", s_stb_o, 1);
                chk("lat_gnt", gnt_o, 2'b01);
                chk("pass_we", s_we_o, 1);
                chk("pass_dat", s_dat_o, 32'hDEADBEEF);
                chk("pass_sel", s_sel_o, 4'hF);
            end
        join
        chk("wr_ok", ok0, 1);
        gnt_q.push_back(2'b01);
        beat(0, 1'b0, 26'h0000100, 32'h0, 3'b000, 1'b1, ok0);
        chk("rd_ok", ok0, 1);

        // both request at reset exit and keep requesting: strict alternation
        do_reset();
        contend = 1;
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(2'b01);
            gnt_q.push_back(2'b10);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) beat(0, 1'b1, 26'h010 + AW'(k), 32'h1000 + k, 3'b000, 1'b1, ok0);
            end
            begin
                for (int k = 0; k < 4; k++) beat(1, 1'b1, 26'h020 + AW'(k), 32'h2000 + k, 3'b000, 1'b1, ok1);
            end
        join
        contend = 0;
        gnt_q.push_back(2'b01);
        beat(0, 1'b0, 26'h013, 32'h0, 3'b000, 1'b1, ok0);
        gnt_q.push_back(2'b10);
        beat(1, 1'b0, 26'h020, 32'h0, 3'b000, 1'b1, ok1);

        // m1 burst is not broken by a waiting m0
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        fork
            begin burst(1, 26'h0000200, 32'hB0000000, ok1); chk("burst_ok", ok1, 1); end
            begin repeat (2) @(posedge wb_clk_i); #1; beat(0, 1'b1, 26'h240, 32'hC0C0C0C0, 3'b000, 1'b1, ok0); end
        join
        gnt_q.push_back(2'b10);
        beat(1, 1'b0, 26'h0000202, 32'h0, 3'b000, 1'b1, ok1);

        // watchdog: stalled slave, m1 waiting behind
        slv_en = 1'b0; stb_cnt = 0; err_cnt = 0; seen = 0;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        fork
            begin beat(0, 1'b1, 26'h180, 32'h11111111, 3'b000, 1'b1, ok0); chk("wd_noack", ok0, 0); end
            begin repeat (2) @(posedge wb_clk_i); #1; beat(1, 1'b1, 26'h1C0, 32'h22222222, 3'b000, 1'b1, ok1); chk("wd_next", ok1, 1); end
            begin
                for (int c = 0; c < 400; c++) begin
                    @(negedge wb_clk_i);
                    if (m_err_o != 0) begin seen = 1; break; end
                end
                chk("wd_seen", seen, 1);
                chk("wd_err_m0", m_err_o, 2'b01);
                chk("wd_cyc", s_cyc_o, 0);
                chk("wd_stb_cycles", stb_cnt, 255);
                slv_en = 1'b1;
            end
        join
        @(negedge wb_clk_i);
        chk("wd_err_once", err_cnt, 1);

        // reset during beat 2 of a write burst
        gnt_q.push_back(2'b01);
        fork
            burst(0, 26'h0000300, 32'hA5A50000, ok0);
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge wb_clk_i);
                    if (m_ack_o[0]) break;
                end
                @(posedge wb_clk_i); #3;
                chk("pre_rst_stb", s_stb_o, 1);
                wb_rst_i = 1'b1;
                #1;
                chk("mid_rst_cyc", s_cyc_o, 0);
                chk("mid_rst_stb", s_stb_o, 0);
                chk("mid_rst_gnt", gnt_o, 0);
                repeat (3) @(posedge wb_clk_i);
                #1 wb_rst_i = 1'b0;
            end
        join
        @(posedge wb_clk_i); #1;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        fork
            begin beat(0, 1'b1, 26'h304, 32'h0BADF00D, 3'b000, 1'b1, ok0); chk("post_rst_wr", ok0, 1); end
            beat(1, 1'b1, 26'h308, 32'h12345678, 3'b000, 1'b1, ok1);
        join
        gnt_q.push_back(2'b01);
        beat(0, 1'b0, 26'h300, 32'h0, 3'b000, 1'b1, ok0);
        gnt_q.push_back(2'b01);
        beat(0, 1'b0, 26'h304, 32'h0, 3'b000, 1'b1, ok0);

        repeat (2) @(negedge wb_clk_i);
        chk("gnt_q_empty", gnt_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1);
    end
endmodule
